// File: rtl/write_controller.sv
// Write side of the Sobel pipeline: takes filtered pixels over valid/ready and
// issues one Avalon-MM word write per pixel into the output frame buffer.
module write_controller #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter logic [31:0] BASE_ADDR  = 32'h0012_C000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        startSobel,
   input  logic        pixValid,
   input  logic [7:0]  pixData,
   output logic        pixReady,
   input  logic        avm_waitrequest,
   output logic [31:0] writeAddress,
   output logic [31:0] writeData,
   output logic        writeEnable,
   output logic        busy,
   output logic        frameDone,
   output logic [8:0]  outRow,
   output logic [9:0]  outCol
);

   localparam logic [31:0] WIDTH_W  = 32'(IMG_WIDTH);
   localparam logic [8:0]  ROW_LAST = 9'(IMG_HEIGHT - 32'd3);
   localparam logic [9:0]  COL_LAST = 10'(IMG_WIDTH - 32'd3);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic [8:0]  row_r, row_s;
   logic [9:0]  col_r, col_s;
   logic [31:0] addr_r, data_r;
   logic        pix_ready_r, write_enable_r, busy_r, frame_done_r;
   logic        accept_s, ack_s, last_s;

   // The +1 offsets place each result under the centre of its 3x3 window.
   function automatic logic [31:0] calc_addr(input logic [8:0] row, input logic [9:0] col);
      logic [31:0] row_w, col_w;
      row_w = {23'd0, row} + 32'd1;
      col_w = {22'd0, col} + 32'd1;
      return BASE_ADDR + ((row_w * WIDTH_W + col_w) * 32'd4);
   endfunction

   function automatic logic [31:0] pack_grey(input logic [7:0] pix);
      return {8'h00, pix, pix, pix};
   endfunction

   assign accept_s = (state_r == ST_ACCEPT) && pixValid;
   assign ack_s    = (state_r == ST_WRITE) && !avm_waitrequest;
   assign last_s   = (row_r == ROW_LAST) && (col_r == COL_LAST);

   // Next-state decode for the frame sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (startSobel) state_s = ST_ACCEPT;
            else            state_s = ST_IDLE;
         end
         ST_ACCEPT: begin
            if (pixValid) state_s = ST_WRITE;
            else          state_s = ST_ACCEPT;
         end
         ST_WRITE: begin
            if (avm_waitrequest) state_s = ST_WRITE;
            else if (last_s)     state_s = ST_DONE;
            else                 state_s = ST_ACCEPT;
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Row/column advance; frozen while a write stalls and after the final pixel.
   always_comb begin
      row_s = row_r;
      col_s = col_r;
      if ((state_r == ST_IDLE) && startSobel) begin
         row_s = 9'd0;
         col_s = 10'd0;
      end else if (ack_s && !last_s) begin
         if (col_r == COL_LAST) begin
            col_s = 10'd0;
            row_s = row_r + 9'd1;
         end else begin
            col_s = col_r + 10'd1;
         end
      end else begin
         row_s = row_r;
         col_s = col_r;
      end
   end

   // State, counters and registered Avalon/handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         row_r          <= 9'd0;
         col_r          <= 10'd0;
         addr_r         <= 32'd0;
         data_r         <= 32'd0;
         pix_ready_r    <= 1'b0;
         write_enable_r <= 1'b0;
         busy_r         <= 1'b0;
         frame_done_r   <= 1'b0;
      end else begin
         state_r        <= state_s;
         row_r          <= row_s;
         col_r          <= col_s;
         pix_ready_r    <= (state_s == ST_ACCEPT);
         write_enable_r <= (state_s == ST_WRITE);
         busy_r         <= (state_s != ST_IDLE);
         frame_done_r   <= (state_s == ST_DONE);
         if (accept_s) begin
            addr_r <= calc_addr(row_r, col_r);
            data_r <= pack_grey(pixData);
         end else begin
            addr_r <= addr_r;
            data_r <= data_r;
         end
      end
   end

   assign pixReady     = pix_ready_r;
   assign writeEnable  = write_enable_r;
   assign writeAddress = addr_r;
   assign writeData    = data_r;
   assign busy         = busy_r;
   assign frameDone    = frame_done_r;
   assign outRow       = row_r;
   assign outCol       = col_r;

endmodule

// File: tb/tb_write_controller.sv
// Directed bench for write_controller: a default-size instance for addressing,
// stalls, wrap and reset, plus an 8x6 instance for a complete frame.
module tb_write_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        startSobel = 1'b0, pixValid = 1'b0, avm_waitrequest = 1'b0;
   logic [7:0]  pixData = 8'h00;
   logic        pixReady, writeEnable, busy, frameDone;
   logic [31:0] writeAddress, writeData;
   logic [8:0]  outRow;
   logic [9:0]  outCol;

   logic        s_start = 1'b0, s_valid = 1'b0, s_wait = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_ready, s_we, s_busy, s_done;
   logic [31:0] s_addr, s_wdata;
   logic [8:0]  s_row;
   logic [9:0]  s_col;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   write_controller dut (
      .clk(clk), .rst(rst), .startSobel(startSobel), .pixValid(pixValid),
      .pixData(pixData), .pixReady(pixReady), .avm_waitrequest(avm_waitrequest),
      .writeAddress(writeAddress), .writeData(writeData), .writeEnable(writeEnable),
      .busy(busy), .frameDone(frameDone), .outRow(outRow), .outCol(outCol)
   );

   write_controller #(.IMG_WIDTH(8), .IMG_HEIGHT(6), .BASE_ADDR(32'h0012_C000)) dut_s (
      .clk(clk), .rst(rst), .startSobel(s_start), .pixValid(s_valid),
      .pixData(s_data), .pixReady(s_ready), .avm_waitrequest(s_wait),
      .writeAddress(s_addr), .writeData(s_wdata), .writeEnable(s_we),
      .busy(s_busy), .frameDone(s_done), .outRow(s_row), .outCol(s_col)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int strobes;
      int dones;
      int b2b;
      logic prev_we;
      logic [31:0] last_addr;

      // reset state
      step(); step();
      rst = 1'b0;
      chk("rst_we",    {31'd0, writeEnable}, 32'd0);
      chk("rst_ready", {31'd0, pixReady},    32'd0);
      chk("rst_busy",  {31'd0, busy},        32'd0);
      chk("rst_done",  {31'd0, frameDone},   32'd0);
      chk("rst_addr",  writeAddress,         32'd0);
      chk("rst_data",  writeData,            32'd0);
      chk("rst_row",   {23'd0, outRow},      32'd0);
      chk("rst_col",   {22'd0, outCol},      32'd0);

      // start, first pixel
      startSobel = 1'b1; step(); startSobel = 1'b0;
      chk("start_ready", {31'd0, pixReady}, 32'd1);
      chk("start_busy",  {31'd0, busy},     32'd1);
      pixValid = 1'b1; pixData = 8'h5A; step(); pixValid = 1'b0;
      chk("p0_we",    {31'd0, writeEnable}, 32'd1);
      chk("p0_addr",  writeAddress,         32'h0012_CA04);
      chk("p0_data",  writeData,            32'h005A_5A5A);
      chk("p0_ready", {31'd0, pixReady},    32'd0);
      step();
      chk("p0_we_off", {31'd0, writeEnable}, 32'd0);
      chk("p0_col",    {22'd0, outCol},      32'd1);

      // three stall cycles, fourth cycle completes
      pixValid = 1'b1; pixData = 8'h33; avm_waitrequest = 1'b1; step(); pixValid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) avm_waitrequest = 1'b0;
         chk("stall_we",    {31'd0, writeEnable}, 32'd1);
         chk("stall_addr",  writeAddress,         32'h0012_CA08);
         chk("stall_data",  writeData,            32'h0033_3333);
         chk("stall_ready", {31'd0, pixReady},    32'd0);
         chk("stall_col",   {22'd0, outCol},      32'd1);
         step();
      end
      chk("stall_we_off", {31'd0, writeEnable}, 32'd0);
      chk("stall_col2",   {22'd0, outCol},      32'd2);

      // stream to the row end with a stray startSobel in the middle
      pixValid = 1'b1; pixData = 8'h10;
      for (int i = 0; i < 1270; i++) begin
         startSobel = (i == 100);
         step();
      end
      startSobel = 1'b0;
      chk("pre_wrap_row", {23'd0, outRow}, 32'd0);
      chk("pre_wrap_col", {22'd0, outCol}, 32'd637);
      chk("pre_wrap_busy", {31'd0, busy},  32'd1);
      step();
      chk("c637_addr", writeAddress, 32'h0012_D3F8);
      step();
      chk("wrap_row", {23'd0, outRow}, 32'd1);
      chk("wrap_col", {22'd0, outCol}, 32'd0);
      step();
      chk("r1c0_addr", writeAddress, 32'h0012_D404);
      step();
      chk("r1c1_col", {22'd0, outCol}, 32'd1);

      // asynchronous reset in the middle of a write
      step();
      chk("pre_rst_we", {31'd0, writeEnable}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_we",    {31'd0, writeEnable}, 32'd0);
      chk("mid_rst_ready", {31'd0, pixReady},    32'd0);
      chk("mid_rst_busy",  {31'd0, busy},        32'd0);
      chk("mid_rst_row",   {23'd0, outRow},      32'd0);
      chk("mid_rst_col",   {22'd0, outCol},      32'd0);
      pixValid = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      startSobel = 1'b1; step(); startSobel = 1'b0;
      pixValid = 1'b1; pixData = 8'h11; step(); pixValid = 1'b0;
      chk("restart_addr", writeAddress, 32'h0012_CA04);
      chk("restart_data", writeData,    32'h0011_1111);
      step();

      // full 8x6 frame: 6x4 outputs, last at row 3 col 5
      strobes = 0; dones = 0; b2b = 0; prev_we = 1'b0; last_addr = 32'd0;
      s_start = 1'b1; step(); s_start = 1'b0;
      s_valid = 1'b1; s_data = 8'h77;
      for (int i = 0; i < 80; i++) begin
         step();
         if (s_we) begin
            strobes++;
            last_addr = s_addr;
            if (prev_we) b2b++;
         end
         if (s_done) dones++;
         prev_we = s_we;
      end
      s_valid = 1'b0;
      chk("frame_strobes", strobes,              32'd24);
      chk("frame_b2b",     b2b,                  32'd0);
      chk("frame_last",    last_addr,            32'h0012_C098);
      chk("frame_dones",   dones,                32'd1);
      chk("frame_busy",    {31'd0, s_busy},      32'd0);
      chk("frame_row",     {23'd0, s_row},       32'd3);
      chk("frame_col",     {22'd0, s_col},       32'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
